// File: rtl/normalization_pipe_pkg.sv
// Shared definitions for the normalization pipe.
//   DEF_MAN_W / DEF_EXP_W : default mantissa-sum and exponent widths
//   SHIFT_LEFT/SHIFT_RIGHT: encoding of the shift_dir output
//   norm_flags_t          : result flag bundle carried by stage 2
package normalization_pipe_pkg;

  localparam int DEF_MAN_W = 12;
  localparam int DEF_EXP_W = 5;

  localparam logic SHIFT_LEFT  = 1'b0;
  localparam logic SHIFT_RIGHT = 1'b1;

  typedef struct packed {
    logic zero;
    logic sticky;
    logic exp_ovf;
    logic exp_unf;
  } norm_flags_t;

endpackage

// File: rtl/lzc_count.sv
// Combinational leading-zero counter over the MAN_W-1 bits below the carry.
//   vec      : mantissa bits [MAN_W-2:0]
//   cnt      : number of zeros above the most significant one (0 when vec==0)
//   all_zero : vec has no set bit
module lzc_count #(
  parameter  int MAN_W = 12,
  localparam int SH_W  = $clog2(MAN_W)
) (
  input  logic [MAN_W-2:0] vec,
  output logic [SH_W-1:0]  cnt,
  output logic             all_zero
);

  // Scan upward; the last (highest) set bit found determines the count.
  always_comb begin
    cnt      = '0;
    all_zero = 1'b1;
    for (int i = 0; i < MAN_W-1; i++) begin
      if (vec[i]) begin
        cnt      = SH_W'(MAN_W-2-i);
        all_zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/normalization_pipe.sv
// Two-stage post-add normalizer with valid/ready handshake.
//   clk, rst_n            : clock, async active-low reset
//   flush                 : synchronous clear of both stages
//   in_valid/in_ready     : input handshake; mantissa_sum, exponent_in
//   out_valid/out_ready   : output handshake
//   norm_mantissa         : leading one at bit MAN_W-2 (or zero)
//   norm_exponent         : adjusted, saturated exponent
//   shift_dir, shift_num  : applied shift (0=left, 1=right) and distance
//   zero, sticky, exp_ovf, exp_unf : result flags
// Stage 1 decides direction/count/zero; stage 2 shifts and adjusts exponent.
module normalization_pipe
  import normalization_pipe_pkg::*;
#(
  parameter  int MAN_W = DEF_MAN_W,
  parameter  int EXP_W = DEF_EXP_W,
  localparam int SH_W  = $clog2(MAN_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAN_W-1:0] mantissa_sum,
  input  logic [EXP_W-1:0] exponent_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAN_W-1:0] norm_mantissa,
  output logic [EXP_W-1:0] norm_exponent,
  output logic             shift_dir,
  output logic [SH_W-1:0]  shift_num,
  output logic             zero,
  output logic             sticky,
  output logic             exp_ovf,
  output logic             exp_unf
);

  localparam int STAGES = 2;
  // Exponent math is one bit wider than either operand so neither
  // overflow nor borrow can wrap silently.
  localparam int AW = ((SH_W > EXP_W) ? SH_W : EXP_W) + 1;
  localparam logic [AW-1:0] EXP_MAX = AW'((1 << EXP_W) - 1);

  logic [STAGES:1] vld_pipe;
  logic            en1, en2;

  assign en2       = out_ready || !vld_pipe[2];
  assign en1       = en2 || !vld_pipe[1];
  assign in_ready  = en1;
  assign out_valid = vld_pipe[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else begin
      if (en1) vld_pipe[1] <= in_valid;
      if (en2) vld_pipe[2] <= vld_pipe[1];
    end
  end

  // ---------------- stage 1: direction, count, zero ----------------
  logic [SH_W-1:0] lz;
  logic            lz_all_zero;

  lzc_count #(.MAN_W(MAN_W)) u_lzc (
    .vec      (mantissa_sum[MAN_W-2:0]),
    .cnt      (lz),
    .all_zero (lz_all_zero)
  );

  logic             carry;
  logic             s1_dir_n;
  logic [SH_W-1:0]  s1_num_n;
  logic             s1_zero_n;

  assign carry     = mantissa_sum[MAN_W-1];
  assign s1_zero_n = !carry && lz_all_zero;
  assign s1_dir_n  = carry ? SHIFT_RIGHT : SHIFT_LEFT;
  assign s1_num_n  = carry ? SH_W'(1) : (lz_all_zero ? '0 : lz);

  logic             s1_dir;
  logic [SH_W-1:0]  s1_num;
  logic             s1_zero;
  logic [MAN_W-1:0] s1_man;
  logic [EXP_W-1:0] s1_exp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_dir  <= SHIFT_LEFT;
      s1_num  <= '0;
      s1_zero <= 1'b0;
      s1_man  <= '0;
      s1_exp  <= '0;
    end else if (en1 && in_valid) begin
      s1_dir  <= s1_dir_n;
      s1_num  <= s1_num_n;
      s1_zero <= s1_zero_n;
      s1_man  <= mantissa_sum;
      s1_exp  <= exponent_in;
    end
  end

  // ---------------- stage 2: shift, exponent, flags ----------------
  logic [AW-1:0]    exp_ext, num_ext, exp_inc, exp_dec;
  logic [MAN_W-1:0] man_n;
  logic [EXP_W-1:0] exp_n;
  norm_flags_t      flags_n;

  always_comb begin
    man_n   = '0;
    exp_n   = '0;
    flags_n = '0;
    exp_ext = AW'(s1_exp);
    num_ext = AW'(s1_num);
    exp_inc = exp_ext + AW'(1);
    exp_dec = exp_ext - num_ext;
    if (s1_zero) begin
      flags_n.zero = 1'b1;
    end else if (s1_dir == SHIFT_RIGHT) begin
      man_n          = s1_man >> 1;
      flags_n.sticky = s1_man[0];
      if (exp_inc > EXP_MAX) begin
        flags_n.exp_ovf = 1'b1;
        exp_n           = EXP_W'(EXP_MAX);
      end else begin
        exp_n = EXP_W'(exp_inc);
      end
    end else if (num_ext > exp_ext) begin
      // Cannot normalise without a negative exponent: flush to zero.
      flags_n.exp_unf = 1'b1;
      flags_n.zero    = 1'b1;
    end else begin
      man_n = s1_man << s1_num;
      exp_n = EXP_W'(exp_dec);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      norm_mantissa <= '0;
      norm_exponent <= '0;
      shift_dir     <= SHIFT_LEFT;
      shift_num     <= '0;
      zero          <= 1'b0;
      sticky        <= 1'b0;
      exp_ovf       <= 1'b0;
      exp_unf       <= 1'b0;
    end else if (en2 && vld_pipe[1]) begin
      norm_mantissa <= man_n;
      norm_exponent <= exp_n;
      shift_dir     <= s1_dir;
      shift_num     <= s1_num;
      zero          <= flags_n.zero;
      sticky        <= flags_n.sticky;
      exp_ovf       <= flags_n.exp_ovf;
      exp_unf       <= flags_n.exp_unf;
    end
  end

endmodule
